mips_register_file: RTL and testbench
=====================================

# mips_register_file

Two-read, one-write general-purpose register file for the 16-bit MIPS-style CPU datapath. It holds 16 registers of 16 bits each, with register 0 hardwired to zero by default. The decode stage reads two operands combinationally. The write-back stage writes one result per clock edge.

## Interface
- DATA_W, 16: register width in bits; data is treated as signed two's complement.
- ADDR_W, 4: register address width; depth is 2**ADDR_W = 16.
- clock  input  1  system clock; all writes occur on its rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- WE  input  1  write enable, sampled at the rising edge of clock.
- InData  input  DATA_W  write data.
- WrReg  input  ADDR_W  write address.
- ReadA  input  ADDR_W  read port A address.
- ReadB  input  ADDR_W  read port B address.
- OutA  output  DATA_W  contents of register ReadA.
- OutB  output  DATA_W  contents of register ReadB.

One clock; reset is asynchronous and active-high.

## Operation
- Storage: 16 x DATA_W flip-flop array; no memory macro.
- Write: at posedge clock, if WE=1 and reset=0, reg[WrReg] <= InData. If WE=0, the array is unchanged regardless of InData or WrReg.
- Read: OutA = reg[ReadA] and OutB = reg[ReadB], purely combinational. Reads have no enable and no output register.
- Both ports may address the same register; each port returns the same value.
- Register 0 (with REGFILE_ZERO_REG_EN): writes to address 0 are dropped, and reads of address 0 return 0.
- Read during write to the same address: the port returns the old value until the clock edge, then the new value. There is no internal write-to-read bypass; forwarding is the pipeline's responsibility.
- No arithmetic. Data passes through bit-exact, so sign bits are preserved.

## Timing
- Write latency: data is visible on OutA/OutB after the rising edge that captured it, after combinational delay only.
- Read latency: zero cycles (combinational from ReadA/ReadB and array state).
- Reset: asserting reset clears all registers to 0 immediately, without waiting for clock. While reset=1, OutA=OutB=0 and writes are ignored.
- Reset deassertion: the first write is accepted on the first rising edge with reset=0 and WE=1.
- Reset mid-write: if reset is high at a clock edge, reset wins and the register stays 0.
- Inputs must be stable around the rising edge of clock; WE, WrReg and InData are sampled together.

## Configuration
- REGFILE_ZERO_REG_EN, defined: register 0 is hardwired to zero, with no storage for it. Writes with WrReg=0 are discarded, and reads of address 0 yield 0.
- REGFILE_ZERO_REG_EN, undefined: register 0 is an ordinary read/write register like registers 1-15.

## Structure
- Shared package regfile_pkg:
  - DATA_W and ADDR_W defaults.
  - NUM_REGS = 16.
  - ZERO_REG = 4'd0.
  - Typedef reg_addr_t (ADDR_W bits).
  - Typedef reg_data_t (signed DATA_W bits).
- One sub-module, regfile_read_port: combinational 16:1 mux from the array to an output, including zero-register masking. It is instantiated twice, for ports A and B.
- The write decode and the array stay in the top module.

## Test plan
- Basic write/read:
  - After reset, WE=1, WrReg=1, InData=10 at an edge -> with ReadA=1, OutA=0x000A.
  - Next edge WE=1, WrReg=2, InData=-200 -> with ReadB=2, OutB=0xFF38 and OutA still 0x000A.
- Write disable: WE=0, WrReg=2, InData=-200, several edges -> OutA=0x000A and OutB=0xFF38 unchanged. Then WE=0 with WrReg=3, InData=0x1234 -> reg3 reads 0x0000.
- Async reset: load reg1=0x000A and reg2=0xFF38, then assert reset between clock edges -> OutA=OutB=0 before the next edge. A write attempted with reset=1 at an edge is ignored.
- Zero register (macro defined): WE=1, WrReg=0, InData=0x7FFF -> ReadA=0 gives OutA=0x0000.
- Zero register (macro undefined): the same stimulus gives OutA=0x7FFF.
- Same-address read/write: reg5=0x0011, then WE=1, WrReg=5, InData=0x0022 with ReadA=ReadB=5 -> both ports show 0x0011 before the edge and 0x0022 after it.
- Exhaustive sweep: write value 0x1000+i to every register i=1..15, then read all registers on both ports -> each returns 0x1000+i with no aliasing.

Source files
------------

// File: rtl/mips_register_file_pkg.sv
// Shared types and sizes for the 16x16 MIPS-style register file.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [ADDR_W-1:0] ZERO_REG = 4'd0;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic signed [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/mips_register_file_if.sv
// Register file bus: one write port, two combinational read ports.
// Optional feature macro: REGFILE_ZERO_REG_EN (no effect on this bus).
interface mips_register_file_if;
  import regfile_pkg::*;

  logic      WE;
  reg_data_t InData;
  reg_addr_t WrReg;
  reg_addr_t ReadA;
  reg_addr_t ReadB;
  reg_data_t OutA;
  reg_data_t OutB;

  modport master (
    output WE, InData, WrReg,
    output ReadA, ReadB,
    input  OutA, OutB
  );

  modport slave (
    input  WE, InData, WrReg,
    input  ReadA, ReadB,
    output OutA, OutB
  );
endinterface

// File: rtl/mips_register_file_read_port.sv
// Combinational 16:1 read mux with optional zero-register masking.
// Optional feature macro: REGFILE_ZERO_REG_EN.
module regfile_read_port
  import regfile_pkg::*;
(
  input  reg_data_t regs [NUM_REGS],
  input  reg_addr_t addr,
  output reg_data_t data
);

  // select the addressed register, forcing zero for register 0 if hardwired
  always_comb begin
    data = regs[addr];
`ifdef REGFILE_ZERO_REG_EN
    if (addr == ZERO_REG) data = '0;
`endif
  end

endmodule

// File: rtl/mips_register_file.sv
// Two-read, one-write register file, 16 x 16-bit flip-flop array.
// Optional feature macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
module mips_register_file
  import regfile_pkg::*;
(
  input logic           clock,
  input logic           reset,
  mips_register_file_if.slave rf
);

`ifdef REGFILE_ZERO_REG_EN
  localparam int FIRST_REG = 1;
`else
  localparam int FIRST_REG = 0;
`endif

  reg_data_t           regs [NUM_REGS];
  logic [NUM_REGS-1:0] wr_sel;

  // one-hot write decode gated by the write enable
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++)
      wr_sel[i] = rf.WE && (rf.WrReg == reg_addr_t'(i));
  end

  // register array: async clear, writable registers start at FIRST_REG
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else begin
      for (int i = FIRST_REG; i < NUM_REGS; i++)
        if (wr_sel[i]) regs[i] <= rf.InData;
    end
  end

  regfile_read_port u_port_a (
    .regs (regs),
    .addr (rf.ReadA),
    .data (rf.OutA)
  );

  regfile_read_port u_port_b (
    .regs (regs),
    .addr (rf.ReadB),
    .data (rf.OutB)
  );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed self-checking bench for mips_register_file.
// Expected register-0 behaviour follows REGFILE_ZERO_REG_EN.
module tb_mips_register_file;
  import regfile_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] zexp;

  mips_register_file_if bus ();

  mips_register_file dut (
    .clock (clock),
    .reset (reset),
    .rf    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a,
                    input logic [15:0] d);
    bus.WE     = 1'b1;
    bus.WrReg  = a;
    bus.InData = d;
    tick();
    bus.WE     = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef REGFILE_ZERO_REG_EN
    zexp = 16'h0000;
`else
    zexp = 16'h7FFF;
`endif
    reset      = 1'b1;
    bus.WE     = 1'b0;
    bus.WrReg  = '0;
    bus.InData = '0;
    bus.ReadA  = 4'd1;
    bus.ReadB  = 4'd2;
    #12;
    chk("rst_a", bus.OutA, 16'h0000);
    chk("rst_b", bus.OutB, 16'h0000);
    reset = 1'b0;

    // basic write/read
    wr(4'd1, 16'd10);
    chk("wr1_a", bus.OutA, 16'h000A);
    wr(4'd2, 16'hFF38);
    chk("wr2_b", bus.OutB, 16'hFF38);
    chk("wr2_a", bus.OutA, 16'h000A);

    // write disable
    bus.WE     = 1'b0;
    bus.WrReg  = 4'd2;
    bus.InData = 16'hFF38;
    repeat (3) tick();
    chk("dis_a", bus.OutA, 16'h000A);
    chk("dis_b", bus.OutB, 16'hFF38);
    bus.WrReg  = 4'd3;
    bus.InData = 16'h1234;
    repeat (2) tick();
    bus.ReadA = 4'd3;
    #1;
    chk("dis_r3", bus.OutA, 16'h0000);

    // same-address read during write
    wr(4'd5, 16'h0011);
    bus.WE     = 1'b1;
    bus.WrReg  = 4'd5;
    bus.InData = 16'h0022;
    bus.ReadA  = 4'd5;
    bus.ReadB  = 4'd5;
    #1;
    chk("rdw_old_a", bus.OutA, 16'h0011);
    chk("rdw_old_b", bus.OutB, 16'h0011);
    tick();
    bus.WE = 1'b0;
    chk("rdw_new_a", bus.OutA, 16'h0022);
    chk("rdw_new_b", bus.OutB, 16'h0022);

    // register 0
    wr(4'd0, 16'h7FFF);
    bus.ReadA = 4'd0;
    bus.ReadB = 4'd0;
    #1;
    chk("zero_a", bus.OutA, zexp);
    chk("zero_b", bus.OutB, zexp);

    // sweep all registers
    for (int i = 1; i < 16; i++)
      wr(4'(i), 16'h1000 + 16'(i));
    for (int i = 0; i < 16; i++) begin
      bus.ReadA = 4'(i);
      bus.ReadB = 4'(15 - i);
      #1;
      chk($sformatf("sweep_a%0d", i), bus.OutA,
          (i == 0) ? zexp : 16'h1000 + 16'(i));
      chk($sformatf("sweep_b%0d", 15 - i), bus.OutB,
          (i == 15) ? zexp : 16'h1000 + 16'(15 - i));
    end

    // asynchronous reset between edges
    wr(4'd1, 16'h000A);
    wr(4'd2, 16'hFF38);
    bus.ReadA = 4'd1;
    bus.ReadB = 4'd2;
    #1;
    chk("pre_rst_a", bus.OutA, 16'h000A);
    chk("pre_rst_b", bus.OutB, 16'hFF38);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_a", bus.OutA, 16'h0000);
    chk("arst_b", bus.OutB, 16'h0000);
    wr(4'd1, 16'h5555);
    chk("rst_wr_a", bus.OutA, 16'h0000);
    #2;
    reset = 1'b0;
    bus.ReadB = 4'd15;
    #1;
    chk("rst_r15", bus.OutB, 16'h0000);
    wr(4'd4, 16'hABCD);
    bus.ReadA = 4'd4;
    #1;
    chk("post_rst_wr", bus.OutA, 16'hABCD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
